// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one single-port memory between an instruction-fetch (IF) port and a
//   load/store (LS) port. One transaction is in flight at a time. A grant fires
//   combinationally in an eligible cycle, and the memory response comes back
//   MEM_LAT cycles later as a one-cycle rvalid to the port that owned the
//   access. A new grant may be issued in the same cycle as the previous
//   response, so MEM_LAT=1 sustains one transaction per cycle.
//
// Parameters:
//   MEM_LAT            memory read latency in cycles (1..4)
//
// Configuration macro:
//   MEM_ARB_ROUND_ROBIN_EN  when defined, contention is won by the port that
//                           did not win last time, and the last-granted register
//                           tracks every grant. When undefined, LS has fixed
//                           priority over IF, and the last-granted register is
//                           not built because it would be the constant IF.
//
// Ports:
//   i_clk, i_rst                      clock (rising edge), synchronous active-high reset
//   i_if_req, i_if_addr               fetch request and byte address
//   o_if_gnt, o_if_rvalid, o_if_rdata fetch grant, response valid, fetched word
//   i_ls_req, i_ls_we, i_ls_addr,
//   i_ls_wdata, i_ls_be               load/store request and payload
//   o_ls_gnt, o_ls_rvalid, o_ls_rdata load/store grant, response valid, load word
//   o_mem_req, o_mem_we, o_mem_addr,
//   o_mem_wdata, o_mem_be             shared memory request side
//   i_mem_rdata                       shared memory read data
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    input  logic        i_ls_req,
    input  logic        i_ls_we,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    input  logic [3:0]  i_ls_be,
    output logic        o_ls_gnt,
    output logic        o_ls_rvalid,
    output logic [31:0] o_ls_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {PORT_IF, PORT_LS} port_t;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    state_t     state;
    logic [2:0] cnt;
    port_t      owner;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    port_t      last;
`endif

    logic  resp_cycle;
    logic  eligible;
    logic  grant;
    port_t winner;

    // The response cycle is also the only WAIT cycle in which a new grant may
    // be issued; reset masks both so every output is quiet while i_rst is high.
    always_comb begin
        resp_cycle = !i_rst && (state == WAIT) && (cnt == 3'd1);
        eligible   = !i_rst && ((state == IDLE) || resp_cycle);
        grant      = eligible && (i_if_req || i_ls_req);
    end

    // Arbitration only matters when both ports request; otherwise the lone
    // requester wins.
    always_comb begin
        winner = PORT_IF;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (i_if_req && i_ls_req) begin
            winner = (last == PORT_IF) ? PORT_LS : PORT_IF;
        end else if (i_ls_req) begin
            winner = PORT_LS;
        end
`else
        if (i_ls_req) begin
            winner = PORT_LS;
        end
`endif
    end

    // Grant, memory request mux and response steering. IF accesses are always
    // full-word reads, so their write-side fields are forced.
    always_comb begin
        o_if_gnt    = 1'b0;
        o_ls_gnt    = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = 32'h0;
        o_mem_wdata = 32'h0;
        o_mem_be    = 4'h0;
        if (grant) begin
            o_mem_req = 1'b1;
            if (winner == PORT_LS) begin
                o_ls_gnt    = 1'b1;
                o_mem_we    = i_ls_we;
                o_mem_addr  = i_ls_addr;
                o_mem_wdata = i_ls_wdata;
                o_mem_be    = i_ls_be;
            end else begin
                o_if_gnt    = 1'b1;
                o_mem_addr  = i_if_addr;
                o_mem_be    = 4'hF;
            end
        end

        o_if_rvalid = resp_cycle && (owner == PORT_IF);
        o_ls_rvalid = resp_cycle && (owner == PORT_LS);
        o_if_rdata  = o_if_rvalid ? i_mem_rdata : 32'h0;
        o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : 32'h0;
    end

    // Transaction FSM. A grant always (re)loads the latency counter, which
    // covers both the IDLE case and back-to-back grants in the response cycle.
    // Reset simply drops any in-flight transaction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            owner <= PORT_IF;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last  <= PORT_IF;
`endif
        end else if (grant) begin
            state <= WAIT;
            cnt   <= LAT_INIT;
            owner <= winner;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last  <= winner;
`endif
        end else if (state == WAIT) begin
            if (cnt == 3'd1) begin
                state <= IDLE;
                cnt   <= 3'd0;
            end else begin
                cnt <= cnt - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Purpose:
//   Drives three mem_arbiter instances (MEM_LAT = 1, 3, 4) from shared inputs.
//   A transaction-level reference model (pending response with a due cycle)
//   predicts every output of every instance each cycle. Table vectors and
//   hand-written sequences add explicit checks for the corner cases.
//   Expectations follow MEM_ARB_ROUND_ROBIN_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic [31:0] mem_rdata;

    logic        if_gnt    [3];
    logic        if_rvalid [3];
    logic [31:0] if_rdata  [3];
    logic        ls_gnt    [3];
    logic        ls_rvalid [3];
    logic [31:0] ls_rdata  [3];
    logic        mem_req   [3];
    logic        mem_we    [3];
    logic [31:0] mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic [3:0]  mem_be    [3];

    int checks = 0;
    int errors = 0;

    // Reference model state: one pending response per instance, with the
    // cycle number it is due in.
    bit pend_valid [3];
    int pend_due   [3];
    bit pend_ls    [3];
    bit last_ls    [3];
    int cyc;

    function automatic int latOf(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_arbiter #(.MEM_LAT((g == 0) ? 1 : ((g == 1) ? 3 : 4))) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_if_req    (if_req),
            .i_if_addr   (if_addr),
            .o_if_gnt    (if_gnt[g]),
            .o_if_rvalid (if_rvalid[g]),
            .o_if_rdata  (if_rdata[g]),
            .i_ls_req    (ls_req),
            .i_ls_we     (ls_we),
            .i_ls_addr   (ls_addr),
            .i_ls_wdata  (ls_wdata),
            .i_ls_be     (ls_be),
            .o_ls_gnt    (ls_gnt[g]),
            .o_ls_rvalid (ls_rvalid[g]),
            .o_ls_rdata  (ls_rdata[g]),
            .o_mem_req   (mem_req[g]),
            .o_mem_we    (mem_we[g]),
            .o_mem_addr  (mem_addr[g]),
            .o_mem_wdata (mem_wdata[g]),
            .o_mem_be    (mem_be[g]),
            .i_mem_rdata (mem_rdata)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison: counts it and reports a mismatch.
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives the requester inputs and a fresh random memory read word.
    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic lreq, input logic lwe,
                                 input logic [31:0] laddr, input logic [31:0] lwdata,
                                 input logic [3:0] lbe);
        if_req    = ireq;
        if_addr   = iaddr;
        ls_req    = lreq;
        ls_we     = lwe;
        ls_addr   = laddr;
        ls_wdata  = lwdata;
        ls_be     = lbe;
        mem_rdata = $urandom();
    endtask

    // Compares all instances against the reference model for the current
    // cycle, then advances the model across the coming clock edge.
    task automatic checkOutput();
        for (int k = 0; k < 3; k++) begin
            bit          rv;
            bit          elig;
            bit          gr;
            bit          win_ls;
            logic [31:0] e_addr;
            logic [31:0] e_wdata;
            logic [3:0]  e_be;
            logic        e_we;
            string       p;
            p      = $sformatf("lat%0d cyc%0d", latOf(k), cyc);
            rv     = !rst && pend_valid[k] && (pend_due[k] == cyc);
            elig   = !rst && (!pend_valid[k] || (pend_due[k] == cyc));
            gr     = elig && (if_req || ls_req);
            if (if_req && ls_req) win_ls = RR ? !last_ls[k] : 1'b1;
            else                  win_ls = ls_req;
            e_we    = gr && win_ls && ls_we;
            e_addr  = !gr ? 32'h0 : (win_ls ? ls_addr : if_addr);
            e_wdata = (gr && win_ls) ? ls_wdata : 32'h0;
            e_be    = !gr ? 4'h0 : (win_ls ? ls_be : 4'hF);

            cmp({p, " if_gnt"},    32'(if_gnt[k]),    32'(gr && !win_ls));
            cmp({p, " ls_gnt"},    32'(ls_gnt[k]),    32'(gr && win_ls));
            cmp({p, " mem_req"},   32'(mem_req[k]),   32'(gr));
            cmp({p, " mem_we"},    32'(mem_we[k]),    32'(e_we));
            cmp({p, " mem_addr"},  mem_addr[k],       e_addr);
            cmp({p, " mem_wdata"}, mem_wdata[k],      e_wdata);
            cmp({p, " mem_be"},    32'(mem_be[k]),    32'(e_be));
            cmp({p, " if_rvalid"}, 32'(if_rvalid[k]), 32'(rv && !pend_ls[k]));
            cmp({p, " ls_rvalid"}, 32'(ls_rvalid[k]), 32'(rv && pend_ls[k]));
            cmp({p, " if_rdata"},  if_rdata[k],       (rv && !pend_ls[k]) ? mem_rdata : 32'h0);
            cmp({p, " ls_rdata"},  ls_rdata[k],       (rv && pend_ls[k]) ? mem_rdata : 32'h0);

            if (rst) begin
                pend_valid[k] = 1'b0;
                last_ls[k]    = 1'b0;
            end else begin
                if (rv) pend_valid[k] = 1'b0;
                if (gr) begin
                    pend_valid[k] = 1'b1;
                    pend_due[k]   = cyc + latOf(k);
                    pend_ls[k]    = win_ls;
                    if (RR) last_ls[k] = win_ls;
                end
            end
        end
        cyc++;
    endtask

    task automatic endCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        checkOutput();
        endCycle();
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        idleInputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [31:0] ls_addr;
        logic [31:0] ls_wdata;
        logic [3:0]  ls_be;
        logic        e_if_gnt;
        logic        e_ls_gnt;
        logic        e_mem_we;
        logic [3:0]  e_mem_be;
        logic [31:0] e_mem_addr;
        logic [31:0] e_mem_wdata;
    } vec_t;

    vec_t vt [6];

    initial begin
        for (int k = 0; k < 3; k++) begin
            pend_valid[k] = 1'b0;
            pend_due[k]   = 0;
            pend_ls[k]    = 1'b0;
            last_ls[k]    = 1'b0;
        end
        cyc = 0;
        rst = 1'b1;
        idleInputs();

        vt[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0,
                  1'b1, 1'b0, 1'b0, 4'hF,    32'h100,  32'h0};
        vt[1] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h2004, 32'h11112222, 4'hF,
                  1'b0, 1'b1, 1'b0, 4'hF,    32'h2004, 32'h11112222};
        vt[2] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011,
                  1'b0, 1'b1, 1'b1, 4'b0011, 32'h2000, 32'hDEADBEEF};
        vt[3] = '{1'b1, 32'h300, 1'b1, 1'b1, 32'h400,  32'hCAFE0000, 4'b1100,
                  1'b0, 1'b1, 1'b1, 4'b1100, 32'h400,  32'hCAFE0000};
        vt[4] = '{1'b0, 32'h500, 1'b0, 1'b1, 32'h600,  32'h1,        4'h1,
                  1'b0, 1'b0, 1'b0, 4'h0,    32'h0,    32'h0};
        vt[5] = '{1'b1, 32'h700, 1'b0, 1'b1, 32'h800,  32'h12345678, 4'h3,
                  1'b1, 1'b0, 1'b0, 4'hF,    32'h700,  32'h0};

        $display("[TB] reset and table vectors");
        doReset();
        for (int i = 0; i < 6; i++) begin
            doReset();
            applyStimulus(vt[i].if_req, vt[i].if_addr, vt[i].ls_req, vt[i].ls_we,
                          vt[i].ls_addr, vt[i].ls_wdata, vt[i].ls_be);
            @(negedge clk);
            cmp($sformatf("vec%0d if_gnt", i),    32'(if_gnt[0]), 32'(vt[i].e_if_gnt));
            cmp($sformatf("vec%0d ls_gnt", i),    32'(ls_gnt[0]), 32'(vt[i].e_ls_gnt));
            cmp($sformatf("vec%0d mem_req", i),   32'(mem_req[0]), 32'(vt[i].e_if_gnt | vt[i].e_ls_gnt));
            cmp($sformatf("vec%0d mem_we", i),    32'(mem_we[0]), 32'(vt[i].e_mem_we));
            cmp($sformatf("vec%0d mem_be", i),    32'(mem_be[0]), 32'(vt[i].e_mem_be));
            cmp($sformatf("vec%0d mem_addr", i),  mem_addr[0], vt[i].e_mem_addr);
            cmp($sformatf("vec%0d mem_wdata", i), mem_wdata[0], vt[i].e_mem_wdata);
            checkOutput();
            endCycle();
            idleInputs();
            @(negedge clk);
            cmp($sformatf("vec%0d if_rvalid", i), 32'(if_rvalid[0]), 32'(vt[i].e_if_gnt));
            cmp($sformatf("vec%0d ls_rvalid", i), 32'(ls_rvalid[0]), 32'(vt[i].e_ls_gnt));
            checkOutput();
            endCycle();
        end

        $display("[TB] single fetch at latency 1");
        doReset();
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        cmp("fetch gnt", 32'(if_gnt[0]), 32'h1);
        cmp("fetch addr", mem_addr[0], 32'h100);
        checkOutput();
        endCycle();
        idleInputs();
        mem_rdata = 32'h00500093;
        @(negedge clk);
        cmp("fetch rvalid", 32'(if_rvalid[0]), 32'h1);
        cmp("fetch rdata", if_rdata[0], 32'h00500093);
        checkOutput();
        endCycle();
        idleInputs();
        @(negedge clk);
        cmp("fetch rvalid after", 32'(if_rvalid[0]), 32'h0);
        checkOutput();
        endCycle();

        $display("[TB] contention at latency 3");
        doReset();
        for (int c = 0; c <= 6; c++) begin
            applyStimulus(1'(c <= 3), 32'h100, 1'(c == 0), 1'b0, 32'h200, 32'h0, 4'hF);
            @(negedge clk);
            cmp($sformatf("lat3 c%0d ls_gnt", c),    32'(ls_gnt[1]),    32'(c == 0));
            cmp($sformatf("lat3 c%0d ls_rvalid", c), 32'(ls_rvalid[1]), 32'(c == 3));
            cmp($sformatf("lat3 c%0d if_gnt", c),    32'(if_gnt[1]),    32'(c == 3));
            cmp($sformatf("lat3 c%0d if_rvalid", c), 32'(if_rvalid[1]), 32'(c == 6));
            checkOutput();
            endCycle();
        end

        $display("[TB] both requesting at latency 1");
        doReset();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 32'h40 + 32'(c), 1'b1, 1'b0, 32'h80 + 32'(c), 32'h0, 4'hF);
            @(negedge clk);
            cmp($sformatf("both c%0d ls_gnt", c), 32'(ls_gnt[0]), RR ? 32'(c % 2 == 0) : 32'h1);
            cmp($sformatf("both c%0d if_gnt", c), 32'(if_gnt[0]), RR ? 32'(c % 2 == 1) : 32'h0);
            checkOutput();
            endCycle();
        end

        $display("[TB] reset during wait at latency 4");
        doReset();
        for (int c = 0; c <= 7; c++) begin
            rst = (c == 2);
            applyStimulus(1'(c == 0 || c == 3), 32'h900, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            @(negedge clk);
            cmp($sformatf("rst c%0d if_gnt", c),    32'(if_gnt[2]),    32'(c == 0 || c == 3));
            cmp($sformatf("rst c%0d if_rvalid", c), 32'(if_rvalid[2]), 32'(c == 7));
            checkOutput();
            endCycle();
        end
        rst = 1'b0;

        $display("[TB] streaming fetches at latency 1");
        doReset();
        for (int c = 0; c <= 8; c++) begin
            applyStimulus(1'(c < 8), 32'h1000 + 32'(4 * c), 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            @(negedge clk);
            cmp($sformatf("stream c%0d if_gnt", c),    32'(if_gnt[0]),    32'(c < 8));
            cmp($sformatf("stream c%0d if_rvalid", c), 32'(if_rvalid[0]), 32'(c >= 1));
            checkOutput();
            endCycle();
        end

        $display("[TB] random traffic");
        doReset();
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            applyStimulus(1'($urandom_range(0, 2) != 0), $urandom(),
                          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                          $urandom(), $urandom(), 4'($urandom_range(0, 15)));
            tick();
        end
        rst = 1'b0;
        idleInputs();
        for (int i = 0; i < 6; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning memory read latency in cycles, legal range 1..4.
REQ-002 SHALL have port i_clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, meaning reset, synchronous and active-high.
REQ-004 SHALL have ports i_if_req (1), i_if_addr (32), as inputs, meaning the instruction-fetch request and its byte address.
REQ-005 SHALL have ports o_if_gnt (1), o_if_rvalid (1), o_if_rdata (32), as outputs, meaning fetch grant, response valid and fetched word.
REQ-006 SHALL have ports i_ls_req (1), i_ls_we (1), i_ls_addr (32), i_ls_wdata (32), i_ls_be (4), as inputs, meaning the load/store request, write enable, address, store data and byte enables.
REQ-007 SHALL have ports o_ls_gnt (1), o_ls_rvalid (1), o_ls_rdata (32), as outputs, meaning load/store grant, response valid and load word.
REQ-008 SHALL have ports o_mem_req (1), o_mem_we (1), o_mem_addr (32), o_mem_wdata (32), o_mem_be (4), as outputs, and port i_mem_rdata (32), as input, meaning the shared single-port memory.

Function
REQ-009 SHALL implement FSM states IDLE and WAIT plus a 3-bit latency counter cnt, the owner register owner (IF/LS) and the last-granted register last.
REQ-010 SHALL issue grants only in IDLE, or in the WAIT cycle where cnt==1; a grant may fire in the same cycle as the previous response.
REQ-011 SHALL assert o_X_gnt combinationally in a grant-eligible cycle when i_X_req=1 and X wins arbitration; at most one gnt is high per cycle.
REQ-012 SHALL, in a grant cycle, drive o_mem_req=1 and drive o_mem_addr/we/wdata/be from the winner; IF grants force we=0, be=4'hF, wdata=0.
REQ-013 SHALL, when no grant is issued, drive o_mem_req=0 with o_mem_we=0 and all other memory outputs at 0.
REQ-014 SHALL, on a grant, set owner=winner, set cnt=MEM_LAT and enter WAIT; in WAIT it decrements cnt each cycle.
REQ-015 SHALL assert o_owner_rvalid for exactly one cycle, when WAIT and cnt==1, i.e. MEM_LAT cycles after the grant.
REQ-016 SHALL drive o_owner_rdata=i_mem_rdata in that cycle and 0 otherwise.
REQ-017 SHALL, in the rvalid cycle, go to IDLE if no new grant is issued and reload WAIT if a new grant is issued.
REQ-018 SHALL also acknowledge stores with rvalid (rdata=i_mem_rdata, don't-care); every grant produces exactly one rvalid.
REQ-019 SHALL rely on requesters holding req and payload stable until gnt; req dropping before gnt is legal and cancels the request.
REQ-020 SHALL ignore requests arriving while WAIT with cnt>1; they wait with gnt=0.
REQ-021 SHALL, with neither req high in a grant-eligible cycle, produce no grant and leave last unchanged.
REQ-022 SHALL, at MEM_LAT=1, sustain one transaction per cycle.

Reset
REQ-023 SHALL, while i_rst=1 at a clock edge, set state=IDLE, cnt=0, owner=IF, last=IF.
REQ-024 SHALL hold all gnt, rvalid, rdata and o_mem_* outputs at 0 during any cycle with i_rst=1.
REQ-025 SHALL discard an in-flight transaction on reset mid-WAIT, with no rvalid afterwards for it; the first grant is possible the cycle after i_rst falls.

Configuration
REQ-026 SHALL have macro MEM_ARB_ROUND_ROBIN_EN; when it is defined, contention is won by the port not equal to last, and last updates to the winner on every grant.
REQ-027 SHALL, when MEM_ARB_ROUND_ROBIN_EN is undefined, use fixed priority LS over IF, with last unused (constant IF).

Verification
REQ-028 SHALL have a bench check this: MEM_LAT=1, IF req addr 0x100 at T, i_mem_rdata=0x00500093 at T+1 -> o_if_gnt at T, o_if_rvalid=1 and o_if_rdata=0x00500093 at T+1 only.
REQ-029 SHALL have a bench check this: MEM_LAT=3, both req at T, fixed priority -> o_ls_gnt at T, o_ls_rvalid at T+3, o_if_gnt at T+3, o_if_rvalid at T+6.
REQ-030 SHALL have a bench check this: MEM_ARB_ROUND_ROBIN_EN, MEM_LAT=1, both req held for 4 cycles after reset -> grants IF... wait, last=IF, so grants LS, IF, LS, IF.
REQ-031 SHALL have a bench check this: store LS we=1, addr 0x2000, wdata 0xDEADBEEF, be=4'b0011 -> o_mem_we=1, o_mem_be=4'b0011 in grant cycle, o_ls_rvalid MEM_LAT later.
REQ-032 SHALL have a bench check this: MEM_LAT=4, i_rst pulsed 2 cycles after grant -> no rvalid ever for that grant, state IDLE, new grant the cycle after i_rst drops.
REQ-033 SHALL have a bench check this: MEM_LAT=1, IF req continuous for 8 cycles -> 8 grants and 8 rvalids on consecutive cycles.
